test_check_pattern: RTL and testbench
=====================================

Name: test_check_pattern

Overview:
- Receive-side checker for the test-pattern Ethernet frames produced by the team's pattern generator.
- Sits after the MAC and Ethernet-header parser. Consumes the parsed header plus the AXI-stream payload, validates every field and the data sequence, and exposes captured timestamp/packet index plus saturating statistics counters.
- Used for loopback and link BER testing.

Parameters:
- DATA_LENGTH, 64: number of data bytes after the 8-byte pattern header; must be >= 2.
- DATA_WIDTH, 8: payload width; only 8 is supported.
- ETH_TYPE, 16'h88B5: expected Ethertype.
- CNT_WIDTH, 32: statistics counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_eth_hdr_valid  in  1  header valid
- s_eth_hdr_ready  out  1  header ready
- s_eth_dest_mac  in  48  destination MAC (not checked)
- s_eth_src_mac  in  48  source MAC (not checked)
- s_eth_type  in  16  Ethertype
- s_eth_payload_axis_tdata  in  DATA_WIDTH  payload byte
- s_eth_payload_axis_tvalid  in  1  payload valid
- s_eth_payload_axis_tready  out  1  payload ready
- s_eth_payload_axis_tlast  in  1  last payload byte
- s_eth_payload_axis_tuser  in  1  bad-frame flag from MAC
- rx_timestamp  out  16  last received timestamp
- rx_timestamp_valid  out  1  1-cycle pulse when rx_timestamp updates
- rx_packet_index  out  16  last received packet index
- frame_done  out  1  1-cycle pulse, frame result valid
- frame_status  out  5  {tuser_err, len_err, seq_err, data_err, hdr_err}; valid with frame_done
- good_count, bad_count, skip_count, data_err_count  out  CNT_WIDTH each  statistics

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - state = S_IDLE.
  - All outputs and counters = 0.
  - seq_sync = 0, data_sync = 0.
- Frame payload order, one byte per accepted beat (fire = tvalid && tready):
  - flag = 8'h07
  - timestamp[7:0], timestamp[15:8]
  - 3 bytes of 8'h00
  - packet_index[7:0], packet_index[15:8]
  - DATA_LENGTH data bytes; tlast is on the final data byte.
- Handshakes:
  - s_eth_hdr_ready = 1 only in S_IDLE.
  - s_eth_payload_axis_tready = 0 in S_IDLE, 1 in all other states.
- States:
  - S_IDLE: on header fire, go to S_TYPE_FLAG if s_eth_type == ETH_TYPE, else S_DROP.
  - S_TYPE_FLAG (1 beat): byte != 8'h07 sets hdr_err.
  - S_TIMESTAMP (2 beats): low byte is latched internally. On the high-byte beat, rx_timestamp updates and rx_timestamp_valid pulses the next cycle.
  - S_3ZEROS (3 beats): any non-zero byte sets hdr_err.
  - S_PACKET_INDEX (2 beats): on the high-byte beat, rx_packet_index updates.
    - If seq_sync is set and index != previous + 1 (mod 2^16), set seq_err.
    - Then set seq_sync = 1.
  - S_DATA (DATA_LENGTH beats): compare against data_expected.
    - If data_sync is set and byte != data_expected, set data_err and increment data_err_count once per bad byte.
    - data_expected <= byte + 1 always (resync, 8-bit wrap 8'hFF -> 8'h00); data_sync <= 1.
    - The expected sequence continues across frames.
  - S_DROP: consume beats until the tlast beat, then return to S_IDLE and increment skip_count. No frame_done.
- Beat counter: count_reg resets to 0 on every state entry.
- Length checks:
  - tlast on any beat before the final data byte: set len_err, end the frame on that beat, go to S_IDLE.
  - tlast absent on the final data byte: set len_err, go to S_DROP. frame_done is still issued at the final data byte; the tail is not counted in skip_count.
- tuser: tuser = 1 on the terminating beat sets tuser_err.
- Frame result:
  - frame_done pulses the cycle after the terminating beat, with frame_status registered.
  - Any error bit set: bad_count++, otherwise good_count++.
  - Error flags clear on frame start.
- Counters saturate at all-ones.
- Back-to-back frames:
  - Header accept may occur the cycle after the terminating beat.
  - The frame_done pulse overlaps the next frame's S_IDLE/S_TYPE_FLAG without interference.
- Reset mid-frame: the frame is abandoned with no frame_done and no counter update. Upstream parser shares rst.

Decomposition:
- Package test_pattern_pkg, shared with the generator:
  - state encodings S_IDLE..S_DATA, plus S_DROP
  - PATTERN_FLAG = 8'h07
  - PATTERN_ETH_TYPE = 16'h88B5
  - header byte counts (TIMESTAMP_BYTES = 2, ZERO_BYTES = 3, INDEX_BYTES = 2)
  - status bit indices
- Sub-module sat_counter (CNT_WIDTH, inc, rst), instanced four times.

Test Plan:
- 3 good frames, index 5,6,7, timestamps 16'h1234/16'h1235/16'h1236, data continuous 0..191 -> 3 frame_done with status 0; good_count = 3; rx_timestamp = 16'h1236; rx_packet_index = 7; pulses 1 cycle after each tlast.
- Index sequence 5, 7 -> second frame seq_err (status 5'b00100); bad_count = 1; rx_packet_index = 7.
- Data byte 10 of frame 2 corrupted to 8'hAA -> data_err, data_err_count = 1, checker resyncs; next frame good.
- tlast on data byte 30 -> len_err, return to S_IDLE. Next, no tlast on byte 63 -> len_err, tail dropped, next frame accepted normally.
- Ethertype 16'h0800 frame of 20 bytes -> skip_count = 1, no frame_done. tuser = 1 on a good frame's tlast -> tuser_err.
- Random tvalid gaps (50%) plus reset asserted during S_DATA -> results identical to the no-gap run; after reset all counters = 0; first frame after reset is good with no seq_err or data_err.

Source files
------------

// File: rtl/test_pattern_pkg.sv
// Shared definitions for the test-pattern generator and checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package test_pattern_pkg;

  // Checker / generator frame walk. The checker parks in S_DROP for frames it ignores.
  typedef enum logic [2:0] {
    S_IDLE,
    S_TYPE_FLAG,
    S_TIMESTAMP,
    S_3ZEROS,
    S_PACKET_INDEX,
    S_DATA,
    S_DROP
  } state_t;

  localparam logic [7:0]  PATTERN_FLAG     = 8'h07;
  localparam logic [15:0] PATTERN_ETH_TYPE = 16'h88B5;

  // Byte counts of the pattern header fields that follow the flag byte.
  localparam int TIMESTAMP_BYTES = 2;
  localparam int ZERO_BYTES      = 3;
  localparam int INDEX_BYTES     = 2;

  // Bit positions inside frame_status.
  localparam int ST_HDR   = 0;
  localparam int ST_DATA  = 1;
  localparam int ST_SEQ   = 2;
  localparam int ST_LEN   = 3;
  localparam int ST_TUSER = 4;

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
// Latency: count reflects inc one cycle later. Ports: clk, rst, inc -> count.
// Backpressure: none; inc is sampled every cycle.
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/test_check_pattern.sv
// Checks received test-pattern frames (parsed header + byte payload), captures timestamp/index, keeps stats.
// Latency: frame_done/frame_status one cycle after the terminating beat; rx_timestamp_valid one cycle after its high byte.
// Backpressure: never stalls payload outside S_IDLE; header accepted only in S_IDLE. Ports: eth header + payload AXI-S in, results/stats out.
module test_check_pattern
  import test_pattern_pkg::*;
#(
  parameter int          DATA_LENGTH = 64,
  parameter int          DATA_WIDTH  = 8,
  parameter logic [15:0] ETH_TYPE    = PATTERN_ETH_TYPE,
  parameter int          CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,
  output logic [15:0]           rx_timestamp,
  output logic                  rx_timestamp_valid,
  output logic [15:0]           rx_packet_index,
  output logic                  frame_done,
  output logic [4:0]            frame_status,
  output logic [CNT_WIDTH-1:0]  good_count,
  output logic [CNT_WIDTH-1:0]  bad_count,
  output logic [CNT_WIDTH-1:0]  skip_count,
  output logic [CNT_WIDTH-1:0]  data_err_count
);

  localparam int            CW        = $clog2(DATA_LENGTH) + 1;
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_LENGTH - 1);

  // MAC addresses are carried for the parser's benefit only.
  logic unused_mac;
  assign unused_mac = ^{s_eth_dest_mac, s_eth_src_mac};

  state_t        state, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [4:0]    err_reg, err_next;
  logic          drop_skip_reg, drop_skip_next;  // drop counts as a skip (foreign Ethertype), not a length-error tail
  logic [7:0]    ts_lo_reg, idx_lo_reg, data_expected;
  logic          seq_sync, data_sync;
  logic [7:0]    byte_in;
  logic          hdr_fire, fire, last_data;
  logic          end_frame, ts_upd, idx_upd, data_beat, data_bad, skip_inc;

  assign byte_in                   = s_eth_payload_axis_tdata[7:0];
  assign s_eth_hdr_ready           = (state == S_IDLE);
  assign s_eth_payload_axis_tready = (state != S_IDLE);
  assign hdr_fire                  = s_eth_hdr_valid && s_eth_hdr_ready;
  assign fire                      = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
  assign last_data                 = (count_reg == LAST_DATA);

  always_comb begin
    state_next     = state;
    err_next       = err_reg;
    drop_skip_next = drop_skip_reg;
    end_frame      = 1'b0;
    ts_upd         = 1'b0;
    idx_upd        = 1'b0;
    data_beat      = 1'b0;
    data_bad       = 1'b0;
    skip_inc       = 1'b0;

    case (state)
      S_IDLE: begin
        if (hdr_fire) begin
          err_next = '0;
          if (s_eth_type == ETH_TYPE) begin
            state_next = S_TYPE_FLAG;
          end else begin
            state_next     = S_DROP;
            drop_skip_next = 1'b1;
          end
        end
      end
      S_TYPE_FLAG: begin
        if (fire) begin
          if (byte_in != PATTERN_FLAG) err_next[ST_HDR] = 1'b1;
          state_next = S_TIMESTAMP;
        end
      end
      S_TIMESTAMP: begin
        if (fire && (count_reg == CW'(TIMESTAMP_BYTES - 1))) begin
          ts_upd     = 1'b1;
          state_next = S_3ZEROS;
        end
      end
      S_3ZEROS: begin
        if (fire) begin
          if (byte_in != 8'h00) err_next[ST_HDR] = 1'b1;
          if (count_reg == CW'(ZERO_BYTES - 1)) state_next = S_PACKET_INDEX;
        end
      end
      S_PACKET_INDEX: begin
        if (fire && (count_reg == CW'(INDEX_BYTES - 1))) begin
          idx_upd = 1'b1;
          // rx_packet_index still holds the previous frame's index here.
          if (seq_sync && ({byte_in, idx_lo_reg} != rx_packet_index + 16'd1))
            err_next[ST_SEQ] = 1'b1;
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (fire) begin
          data_beat = 1'b1;
          if (data_sync && (byte_in != data_expected)) begin
            data_bad          = 1'b1;
            err_next[ST_DATA] = 1'b1;
          end
          if (last_data) state_next = S_IDLE;
        end
      end
      S_DROP: begin
        if (fire && s_eth_payload_axis_tlast) begin
          state_next = S_IDLE;
          skip_inc   = drop_skip_reg;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Frame termination: either the final data byte, or an early tlast anywhere in the pattern.
    if (fire && (state != S_IDLE) && (state != S_DROP)) begin
      if ((state == S_DATA) && last_data) begin
        end_frame = 1'b1;
        if (!s_eth_payload_axis_tlast) begin
          // Overlong frame: report now, swallow the tail without calling it a skip.
          err_next[ST_LEN] = 1'b1;
          state_next       = S_DROP;
          drop_skip_next   = 1'b0;
        end
      end else if (s_eth_payload_axis_tlast) begin
        end_frame        = 1'b1;
        err_next[ST_LEN] = 1'b1;
        state_next       = S_IDLE;
      end
      if (end_frame && s_eth_payload_axis_tuser) err_next[ST_TUSER] = 1'b1;
    end

    if (state_next != state) count_next = '0;
    else if (fire)           count_next = count_reg + CW'(1);
    else                     count_next = count_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      count_reg          <= '0;
      err_reg            <= '0;
      drop_skip_reg      <= 1'b0;
      ts_lo_reg          <= '0;
      idx_lo_reg         <= '0;
      data_expected      <= '0;
      seq_sync           <= 1'b0;
      data_sync          <= 1'b0;
      rx_timestamp       <= '0;
      rx_timestamp_valid <= 1'b0;
      rx_packet_index    <= '0;
      frame_done         <= 1'b0;
      frame_status       <= '0;
    end else begin
      state              <= state_next;
      count_reg          <= count_next;
      err_reg            <= err_next;
      drop_skip_reg      <= drop_skip_next;
      frame_done         <= end_frame;
      rx_timestamp_valid <= ts_upd;
      if (end_frame) frame_status <= err_next;
      if ((state == S_TIMESTAMP) && fire && (count_reg == '0)) ts_lo_reg <= byte_in;
      if ((state == S_PACKET_INDEX) && fire && (count_reg == '0)) idx_lo_reg <= byte_in;
      if (ts_upd) rx_timestamp <= {byte_in, ts_lo_reg};
      if (idx_upd) begin
        rx_packet_index <= {byte_in, idx_lo_reg};
        seq_sync        <= 1'b1;
      end
      // Always resync to the received byte so one bad byte is flagged once, not forever.
      if (data_beat) begin
        data_expected <= byte_in + 8'd1;
        data_sync     <= 1'b1;
      end
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_good (
    .clk(clk), .rst(rst), .inc(end_frame && (err_next == '0)), .count(good_count)
  );
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bad (
    .clk(clk), .rst(rst), .inc(end_frame && (err_next != '0)), .count(bad_count)
  );
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_skip (
    .clk(clk), .rst(rst), .inc(skip_inc), .count(skip_count)
  );
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_data_err (
    .clk(clk), .rst(rst), .inc(data_bad), .count(data_err_count)
  );

endmodule

// File: tb/tb_test_check_pattern.sv
// Bench for test_check_pattern: directed frames, expected frame_status queued per frame, monitor pops on frame_done.
// Latency: checks frame_done lands exactly one cycle after each terminating beat.
// Backpressure: optional random tvalid gaps from the driver.
module tb_test_check_pattern;

  localparam int DL = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hdr_valid = 1'b0;
  logic        hdr_ready;
  logic [15:0] eth_type = 16'h0;
  logic [7:0]  tdata = 8'h0;
  logic        tvalid = 1'b0, tready, tlast = 1'b0, tuser = 1'b0;
  logic [15:0] rx_timestamp, rx_packet_index;
  logic        rx_timestamp_valid, frame_done;
  logic [4:0]  frame_status;
  logic [31:0] good_count, bad_count, skip_count, data_err_count;

  always #5 clk = ~clk;

  test_check_pattern #(
    .DATA_LENGTH(DL), .DATA_WIDTH(8), .ETH_TYPE(16'h88B5), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(hdr_valid), .s_eth_hdr_ready(hdr_ready),
    .s_eth_dest_mac(48'h0200_0000_0001), .s_eth_src_mac(48'h0200_0000_0002),
    .s_eth_type(eth_type),
    .s_eth_payload_axis_tdata(tdata), .s_eth_payload_axis_tvalid(tvalid),
    .s_eth_payload_axis_tready(tready), .s_eth_payload_axis_tlast(tlast),
    .s_eth_payload_axis_tuser(tuser),
    .rx_timestamp(rx_timestamp), .rx_timestamp_valid(rx_timestamp_valid),
    .rx_packet_index(rx_packet_index),
    .frame_done(frame_done), .frame_status(frame_status),
    .good_count(good_count), .bad_count(bad_count),
    .skip_count(skip_count), .data_err_count(data_err_count)
  );

  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_q[$];
  logic       term_drv = 1'b0;   // current beat is the one that should end a checked frame
  logic       pend = 1'b0;       // a terminating beat fires at the coming edge
  bit         gaps = 1'b0;
  int         ts_pulses = 0;
  logic [7:0] dseq = 8'h00;      // generator data sequence

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: inputs change just after posedge, so the negedge sees stable values.
  always @(negedge clk) begin
    if (rx_timestamp_valid) ts_pulses++;
    if (frame_done || pend) chk("frame_done_timing", {31'd0, frame_done}, {31'd0, pend});
    if (frame_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done status=%0b", frame_status);
      end else begin
        chk("frame_status", {27'd0, frame_status}, {27'd0, exp_q.pop_front()});
      end
    end
    pend = tvalid && tready && term_drv && !rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hdr(input logic [15:0] t);
    int n = 0;
    hdr_valid = 1'b1;
    eth_type  = t;
    while (!hdr_ready) begin
      step();
      n++;
      if (n > 1000) begin
        $display("FAIL hdr_timeout actual=stalled required=ready");
        $fatal(1);
      end
    end
    step();
    hdr_valid = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input bit last, input bit user, input bit term);
    int n = 0;
    forever begin
      if (gaps && ($urandom_range(0, 1) == 0)) begin
        tvalid = 1'b0;
        step();
      end else begin
        tvalid = 1'b1; tdata = d; tlast = last; tuser = user; term_drv = term;
        if (tready) begin
          step();
          break;
        end
        step();
      end
      n++;
      if (n > 1000) begin
        $display("FAIL beat_timeout actual=stalled required=accepted");
        $fatal(1);
      end
    end
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; term_drv = 1'b0;
  endtask

  // last_pos: beat carrying tlast (8+DL-1 normal; beyond that adds a dropped tail).
  // corrupt: data index replaced by 8'hAA, stream then jumps to follow it. abort_pos: stop before that beat.
  task automatic frame(input logic [15:0] ts, input logic [15:0] idx, input int last_pos,
                       input int corrupt, input bit user, input int abort_pos,
                       input logic [4:0] exp_status);
    int         total = 8 + DL;
    int         term_pos = (last_pos < total) ? last_pos : total - 1;
    logic [7:0] b;
    if (abort_pos < 0) exp_q.push_back(exp_status);
    hdr(16'h88B5);
    for (int i = 0; i <= last_pos; i++) begin
      if ((abort_pos >= 0) && (i == abort_pos)) break;
      case (i)
        0:       b = 8'h07;
        1:       b = ts[7:0];
        2:       b = ts[15:8];
        3, 4, 5: b = 8'h00;
        6:       b = idx[7:0];
        7:       b = idx[15:8];
        default: begin
          if (i >= total) b = 8'h55;
          else if ((i - 8) == corrupt) begin
            b = 8'hAA;
            dseq = 8'hAB;
          end else begin
            b = dseq;
            dseq = dseq + 8'd1;
          end
        end
      endcase
      beat(b, i == last_pos, user && (i == term_pos), (i == term_pos) && (abort_pos < 0));
    end
  endtask

  task automatic other(input logic [15:0] t, input int n);
    hdr(t);
    for (int i = 0; i < n; i++) beat(8'(i), i == n - 1, 1'b0, 1'b0);
  endtask

  task automatic stats(input string tag, input int g, input int b, input int s, input int de,
                       input logic [15:0] ts, input logic [15:0] idx);
    step(); step();
    chk($sformatf("%s_good", tag), good_count, 32'(g));
    chk($sformatf("%s_bad", tag), bad_count, 32'(b));
    chk($sformatf("%s_skip", tag), skip_count, 32'(s));
    chk($sformatf("%s_data_err", tag), data_err_count, 32'(de));
    chk($sformatf("%s_timestamp", tag), {16'd0, rx_timestamp}, {16'd0, ts});
    chk($sformatf("%s_index", tag), {16'd0, rx_packet_index}, {16'd0, idx});
  endtask

  localparam int NORM = 8 + DL - 1;

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();
    stats("reset", 0, 0, 0, 0, 16'h0, 16'h0);
    chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
    chk("reset_ts_valid", {31'd0, rx_timestamp_valid}, 32'd0);
    chk("reset_hdr_ready", {31'd0, hdr_ready}, 32'd1);
    chk("reset_tready", {31'd0, tready}, 32'd0);

    // Three good frames, data 0..191.
    dseq = 8'h00;
    frame(16'h1234, 16'd5, NORM, -1, 1'b0, -1, 5'b00000);
    frame(16'h1235, 16'd6, NORM, -1, 1'b0, -1, 5'b00000);
    frame(16'h1236, 16'd7, NORM, -1, 1'b0, -1, 5'b00000);
    stats("good3", 3, 0, 0, 0, 16'h1236, 16'd7);
    chk("good3_ts_pulses", 32'(ts_pulses), 32'd3);

    // Index jumps 7 -> 9; data 192..255.
    frame(16'h1237, 16'd9, NORM, -1, 1'b0, -1, 5'b00100);
    stats("seq", 3, 1, 0, 0, 16'h1237, 16'd9);

    // Data wraps to 0; byte 10 is 8'hAA, then resync and a clean frame.
    frame(16'h1238, 16'd10, NORM, 10, 1'b0, -1, 5'b00010);
    stats("data", 3, 2, 0, 1, 16'h1238, 16'd10);
    frame(16'h1239, 16'd11, NORM, -1, 1'b0, -1, 5'b00000);
    stats("resync", 4, 2, 0, 1, 16'h1239, 16'd11);

    // Short frame (tlast on data byte 30), long frame (3-byte tail), then clean.
    frame(16'h123A, 16'd12, 8 + 30, -1, 1'b0, -1, 5'b01000);
    stats("short", 4, 3, 0, 1, 16'h123A, 16'd12);
    frame(16'h123B, 16'd13, NORM + 3, -1, 1'b0, -1, 5'b01000);
    stats("long", 4, 4, 0, 1, 16'h123B, 16'd13);
    frame(16'h123C, 16'd14, NORM, -1, 1'b0, -1, 5'b00000);
    stats("after_len", 5, 4, 0, 1, 16'h123C, 16'd14);

    // Foreign Ethertype is skipped; tuser flagged on tlast.
    other(16'h0800, 20);
    stats("skip", 5, 4, 1, 1, 16'h123C, 16'd14);
    frame(16'h123D, 16'd15, NORM, -1, 1'b1, -1, 5'b10000);
    stats("tuser", 5, 5, 1, 1, 16'h123D, 16'd15);
    frame(16'h123E, 16'd16, NORM, -1, 1'b0, -1, 5'b00000);
    stats("clean", 6, 5, 1, 1, 16'h123E, 16'd16);

    // Gapped traffic, reset mid-data, then the first run repeated.
    gaps = 1'b1;
    frame(16'h2000, 16'd20, NORM, -1, 1'b0, 8 + 20, 5'b00000);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    stats("midreset", 0, 0, 0, 0, 16'h0, 16'h0);
    ts_pulses = 0;
    dseq = 8'h00;
    frame(16'h1234, 16'd5, NORM, -1, 1'b0, -1, 5'b00000);
    frame(16'h1235, 16'd6, NORM, -1, 1'b0, -1, 5'b00000);
    frame(16'h1236, 16'd7, NORM, -1, 1'b0, -1, 5'b00000);
    stats("gapped", 3, 0, 0, 0, 16'h1236, 16'd7);
    chk("gapped_ts_pulses", 32'(ts_pulses), 32'd3);

    step(); step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
